writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Write-side driver for the 32x64 integer register file.
- Collects results from two producers and serializes them into the file's single write port, one write per cycle:
  - port A: ALU pipe, priority.
  - port B: long-latency unit (LSU / mul-div).
- Maintains a busy scoreboard of registers with an issued-but-not-written result, so decode can stall on RAW and WAW hazards.

Parameters:
STARVE_LIMIT, 4, consecutive cycles port B may be valid and not granted before it is forced to win the next arbitration (1..15)
XLEN, 64, data width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
a_valid_i  input  1  port A result valid
a_ready_o  output  1  port A accepted this cycle
a_rd_i  input  5  port A destination register
a_data_i  input  XLEN  port A result
b_valid_i  input  1  port B result valid
b_ready_o  output  1  port B accepted this cycle
b_rd_i  input  5  port B destination register
b_data_i  input  XLEN  port B result
issue_valid_i  input  1  decode issued an instruction writing issue_rd_i
issue_rd_i  input  5  destination of the issued instruction
wr_reg_en_o  output  1  register file write enable
rd_o  output  5  register file write address
wr_reg_data_o  output  XLEN  register file write data
busy_o  output  32  bit n set = register n has a pending write
fwd_valid_o  output  1  bypass valid (optional feature)
fwd_rd_o  output  5  bypass register (optional feature)
fwd_data_o  output  XLEN  bypass data (optional feature)

Behaviour:
- Interface fixed: one clock clk_i; rst_i synchronous, active-high.
- Reset: wr_reg_en_o=0, rd_o=0, wr_reg_data_o=0, busy_o=0, starvation counter=0.
  - a_ready_o=b_ready_o=0 while rst_i=1.
  - Reset mid-stream discards any result being offered that cycle.
- Arbitration: combinational; ready goes to at most one port per cycle.
  - Default: grant A if a_valid_i, else grant B if b_valid_i.
  - Starvation counter increments each cycle b_valid_i=1 and B is not granted.
  - It clears when B is granted or b_valid_i=0.
  - When counter==STARVE_LIMIT, B is granted even if a_valid_i=1; A sees a_ready_o=0 and must hold its valid, rd and data.
- Ready is not conditioned on anything but arbitration; there is no backpressure from the register file.
- Output stage: registered, latency 1.
  - Handshake at edge N drives the write during cycle N+1:
    - wr_reg_en_o=1 when granted rd!=0;
    - rd_o = granted rd;
    - wr_reg_data_o = granted data.
  - rd==0: handshake completes but wr_reg_en_o=0.
  - No handshake: wr_reg_en_o=0.
  - Whenever wr_reg_en_o=0, rd_o=0 and wr_reg_data_o=0, so read-side forwarding keyed on rd sees only x0.
- Scoreboard:
  - issue_valid_i with issue_rd_i!=0 sets busy[issue_rd_i] at the clock edge.
  - A handshake with rd!=0 clears busy[rd] at the same edge the output stage registers it.
  - Set and clear of the same register at the same edge: set wins.
  - busy_o[0] is constant 0.
  - Decode never issues to a busy register (WAW stall), so there is at most one pending write per register.
  - A result arriving for a non-busy register is still written; the clear is a no-op.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - fwd_valid_o = handshake this cycle with rd!=0;
  - fwd_rd_o and fwd_data_o = the granted rd and data, combinational, one cycle ahead of the register file write.
  - All three are 0 when there is no such handshake.
- Undefined: fwd_valid_o, fwd_rd_o and fwd_data_o are tied to 0; no bypass logic is synthesized.

Decomposition:
- Package wb_pkg:
  - XLEN, REG_ADDR_W=5, NUM_REGS=32;
  - typedef wb_req_t {rd, data};
  - enum wb_src_e {WB_SRC_NONE, WB_SRC_A, WB_SRC_B}.
- Sub-module wb_scoreboard: busy vector with set/clear ports and the set-wins rule.
- Arbiter, starvation counter and output register stay in the top.

Test Plan:
- Reset: hold rst_i 2 cycles with both ports valid -> readies 0, wr_reg_en_o=0, busy_o=0.
- Single write: A offers rd=5, data=0xDEAD_BEEF -> a_ready_o=1; next cycle wr_reg_en_o=1, rd_o=5, wr_reg_data_o=0xDEAD_BEEF; following cycle wr_reg_en_o=0, rd_o=0.
- Starvation, STARVE_LIMIT=4: A and B both valid continuously -> A wins 4 cycles, B wins cycle 5, A wins again from cycle 6.
- x0 discard: B offers rd=0, data=0x1234 -> b_ready_o=1; next cycle wr_reg_en_o=0, rd_o=0, wr_reg_data_o=0.
- Scoreboard: issue rd=7 -> busy_o[7]=1 next cycle. Later, issue rd=7 at the same edge a B result for rd=7 handshakes -> busy_o[7] stays 1. A second B write to rd=7 -> busy_o[7]=0.
- WB_BYPASS_EN defined: A offers rd=3, data=0x55 -> same cycle fwd_valid_o=1, fwd_rd_o=3, fwd_data_o=0x55. Undefined: all three stay 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths, request type and grant-source encoding for the integer
// register-file writeback path.
package wb_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_A    = 2'd1,
        WB_SRC_B    = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared
// on writeback; a set and clear hitting the same register together leaves it set.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_rd,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_rd,
    output logic [NUM_REGS-1:0]   o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    assign w_set = i_set_en ? (NUM_REGS'(1) << i_set_rd) : '0;
    assign w_clr = i_clr_en ? (NUM_REGS'(1) << i_clr_rd) : '0;

    // x0 can never hold a pending write, so bit 0 is forced low every edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/writeback_arbiter.sv
// Two-producer writeback arbiter (A priority, B starvation-protected) feeding the
// single register-file write port. Optional same-cycle bypass under WB_BYPASS_EN.
module writeback_arbiter
    import wb_pkg::REG_ADDR_W, wb_pkg::NUM_REGS, wb_pkg::wb_src_e,
           wb_pkg::WB_SRC_NONE, wb_pkg::WB_SRC_A, wb_pkg::WB_SRC_B;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [REG_ADDR_W-1:0] a_rd_i,
    input  logic [XLEN-1:0]       a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [REG_ADDR_W-1:0] b_rd_i,
    input  logic [XLEN-1:0]       b_data_i,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    output logic                  wr_reg_en_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [XLEN-1:0]       wr_reg_data_o,
    output logic [NUM_REGS-1:0]   busy_o,
    output logic                  fwd_valid_o,
    output logic [REG_ADDR_W-1:0] fwd_rd_o,
    output logic [XLEN-1:0]       fwd_data_o
);

    wb_src_e               w_src;
    logic [REG_ADDR_W-1:0] w_gnt_rd;
    logic [XLEN-1:0]       w_gnt_data;
    logic                  w_wr_en;
    logic [3:0]            r_starve;
    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_data;

    // B overrides A once it has waited STARVE_LIMIT cycles in a row.
    always_comb begin
        w_src = WB_SRC_NONE;
        if (!rst_i) begin
            if (b_valid_i && (!a_valid_i || r_starve == 4'(STARVE_LIMIT)))
                w_src = WB_SRC_B;
            else if (a_valid_i)
                w_src = WB_SRC_A;
        end
    end

    always_comb begin
        w_gnt_rd   = '0;
        w_gnt_data = '0;
        case (w_src)
            WB_SRC_A: begin
                w_gnt_rd   = a_rd_i;
                w_gnt_data = a_data_i;
            end
            WB_SRC_B: begin
                w_gnt_rd   = b_rd_i;
                w_gnt_data = b_data_i;
            end
            default: ;
        endcase
    end

    assign a_ready_o = (w_src == WB_SRC_A);
    assign b_ready_o = (w_src == WB_SRC_B);
    assign w_wr_en   = (w_src != WB_SRC_NONE) && (w_gnt_rd != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || !b_valid_i || b_ready_o)
            r_starve <= '0;
        else
            r_starve <= r_starve + 4'd1;
    end

    // Address and data are zeroed on idle cycles so rd-keyed consumers only ever see x0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_en <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
        end else begin
            r_wr_en <= w_wr_en;
            r_rd    <= w_wr_en ? w_gnt_rd : '0;
            r_data  <= w_wr_en ? w_gnt_data : '0;
        end
    end

    assign wr_reg_en_o   = r_wr_en;
    assign rd_o          = r_rd;
    assign wr_reg_data_o = r_data;

    wb_scoreboard u_scoreboard (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_set_en (issue_valid_i && (issue_rd_i != '0)),
        .i_set_rd (issue_rd_i),
        .i_clr_en (w_wr_en),
        .i_clr_rd (w_gnt_rd),
        .o_busy   (busy_o)
    );

`ifdef WB_BYPASS_EN
    assign fwd_valid_o = w_wr_en;
    assign fwd_rd_o    = w_wr_en ? w_gnt_rd : '0;
    assign fwd_data_o  = w_wr_en ? w_gnt_data : '0;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_rd_o    = '0;
    assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes are queued when a grant
// is predicted and compared one edge later against the register-file port.
module tb_writeback_arbiter;

    localparam int LIM = 4;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_wr_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        a_valid_i, b_valid_i, issue_valid_i;
    logic        a_ready_o, b_ready_o;
    logic [4:0]  a_rd_i, b_rd_i, issue_rd_i, rd_o, fwd_rd_o;
    logic [63:0] a_data_i, b_data_i, wr_reg_data_o, fwd_data_o;
    logic        wr_reg_en_o, fwd_valid_o;
    logic [31:0] busy_o;

    exp_wr_t     q_exp[$];
    logic [31:0] m_busy = '0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.STARVE_LIMIT(LIM), .XLEN(64)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_rd_i(a_rd_i), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_rd_i(b_rd_i), .b_data_i(b_data_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .wr_reg_en_o(wr_reg_en_o), .rd_o(rd_o), .wr_reg_data_o(wr_reg_data_o),
        .busy_o(busy_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One cycle: check readies/bypass against the predicted grant, push the
    // expected write, clock, then pop and check the write port and busy vector.
    task automatic step(input string tag, input logic ea, input logic eb);
        exp_wr_t     e;
        exp_wr_t     got;
        logic [31:0] set_m, clr_m;
        #1;
        chk({tag, ".a_ready"}, 64'(a_ready_o), 64'(ea));
        chk({tag, ".b_ready"}, 64'(b_ready_o), 64'(eb));
        e.en = 1'b0; e.rd = '0; e.data = '0;
        if (ea && a_rd_i != 0) begin e.en = 1'b1; e.rd = a_rd_i; e.data = a_data_i; end
        if (eb && b_rd_i != 0) begin e.en = 1'b1; e.rd = b_rd_i; e.data = b_data_i; end
`ifdef WB_BYPASS_EN
        chk({tag, ".fwd_valid"}, 64'(fwd_valid_o), 64'(e.en));
        chk({tag, ".fwd_rd"},    64'(fwd_rd_o),    64'(e.rd));
        chk({tag, ".fwd_data"},  fwd_data_o,       e.data);
`else
        chk({tag, ".fwd_valid"}, 64'(fwd_valid_o), 64'd0);
        chk({tag, ".fwd_rd"},    64'(fwd_rd_o),    64'd0);
        chk({tag, ".fwd_data"},  fwd_data_o,       64'd0);
`endif
        q_exp.push_back(e);
        set_m = (issue_valid_i && issue_rd_i != 0) ? (32'd1 << issue_rd_i) : 32'd0;
        clr_m = e.en ? (32'd1 << e.rd) : 32'd0;
        m_busy = rst_i ? 32'd0 : (((m_busy & ~clr_m) | set_m) & 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        got = q_exp.pop_front();
        chk({tag, ".wr_en"},   64'(wr_reg_en_o), 64'(got.en));
        chk({tag, ".rd"},      64'(rd_o),        64'(got.rd));
        chk({tag, ".wr_data"}, wr_reg_data_o,    got.data);
        chk({tag, ".busy"},    64'(busy_o),      64'(m_busy));
    endtask

    initial begin
        rst_i = 1'b1;
        a_valid_i = 1'b1; a_rd_i = 5'd1; a_data_i = 64'h11;
        b_valid_i = 1'b1; b_rd_i = 5'd2; b_data_i = 64'h22;
        issue_valid_i = 1'b0; issue_rd_i = '0;

        step("rst0", 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b0);

        rst_i = 1'b0; b_valid_i = 1'b0;
        a_rd_i = 5'd5; a_data_i = 64'hDEAD_BEEF;
        step("single", 1'b1, 1'b0);
        a_valid_i = 1'b0;
        step("idle0", 1'b0, 1'b0);
        step("idle1", 1'b0, 1'b0);

        a_valid_i = 1'b1; a_rd_i = 5'd10; a_data_i = 64'hA0A0_0000_0000_000A;
        b_valid_i = 1'b1; b_rd_i = 5'd11; b_data_i = 64'hB0B0_0000_0000_000B;
        for (int i = 0; i < LIM; i++) step("starve_a", 1'b1, 1'b0);
        step("starve_b", 1'b0, 1'b1);
        step("starve_a_again", 1'b1, 1'b0);
        b_valid_i = 1'b0;
        step("starve_clr", 1'b1, 1'b0);
        b_valid_i = 1'b1;
        for (int i = 0; i < LIM; i++) step("restart_a", 1'b1, 1'b0);
        step("restart_b", 1'b0, 1'b1);
        a_valid_i = 1'b0; b_valid_i = 1'b0;

        b_valid_i = 1'b1; b_rd_i = 5'd0; b_data_i = 64'h1234;
        step("x0_discard", 1'b0, 1'b1);
        b_valid_i = 1'b0;

        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        step("issue7", 1'b0, 1'b0);
        issue_valid_i = 1'b1; issue_rd_i = 5'd0;
        step("issue_x0", 1'b0, 1'b0);
        issue_rd_i = 5'd7;
        b_valid_i = 1'b1; b_rd_i = 5'd7; b_data_i = 64'h7777;
        step("set_wins", 1'b0, 1'b1);
        issue_valid_i = 1'b0;
        b_data_i = 64'h7778;
        step("clear7", 1'b0, 1'b1);
        b_valid_i = 1'b0;

        a_valid_i = 1'b1; a_rd_i = 5'd3; a_data_i = 64'h55;
        issue_valid_i = 1'b1; issue_rd_i = 5'd12;
        step("bypass3", 1'b1, 1'b0);
        issue_valid_i = 1'b0;
        a_rd_i = 5'd31; a_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
        step("rd31", 1'b1, 1'b0);

        rst_i = 1'b1; a_rd_i = 5'd9; a_data_i = 64'h99;
        b_valid_i = 1'b1; b_rd_i = 5'd12; b_data_i = 64'hCC;
        step("mid_rst", 1'b0, 1'b0);
        rst_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;
        step("post_rst", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
